// File: rtl/fir_tap_sequencer_pkg.sv
// Shared state type and index helpers for the FIR tap sequencer and its history ring.
package fir_tap_sequencer_pkg;

   typedef enum logic [1:0] {CLEAR, IDLE, RUN} state_e;

   function automatic int ptr_w(input int ntaps);
      return $clog2(ntaps);
   endfunction

   // (base - k) mod n, valid for base < n and k <= n; n need not be a power of two.
   function automatic int unsigned wrap_sub(input int unsigned base, input int unsigned k,
                                            input int unsigned n);
      return (base >= k) ? base - k : base + n - k;
   endfunction

endpackage

// File: rtl/fir_tap_ring.sv
// Circular sample history: one write port shared by clear and push, one asynchronous read port.
module fir_tap_ring
   import fir_tap_sequencer_pkg::*;
#(
   parameter  int ADW   = 24,
   parameter  int NTAPS = 16,
   localparam int AW    = ptr_w(NTAPS)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr_en_i,
   input  logic [AW-1:0]  clr_idx_i,
   input  logic           push_en_i,
   input  logic [ADW-1:0] push_data_i,
   input  logic           adv_i,
   input  logic [AW-1:0]  tap_i,
   output logic [ADW-1:0] rd_data_o
);

   logic [ADW-1:0] mem [NTAPS];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  wr_addr;
   logic [AW-1:0]  rd_idx;

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (adv_i) begin
         wr_ptr_d = (wr_ptr_q == AW'(NTAPS-1)) ? '0 : wr_ptr_q + AW'(1);
      end
   end

   assign wr_addr   = clr_en_i ? clr_idx_i : wr_ptr_q;
   assign rd_idx    = AW'(wrap_sub(32'(wr_ptr_q), 32'(tap_i), 32'(NTAPS)));
   assign rd_data_o = mem[rd_idx];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // NOTE: the storage array has no reset; the CLEAR pass zeroes it, keeping it mappable to RAM.
   always_ff @(posedge clk) begin
      if (clr_en_i || push_en_i) begin
         mem[wr_addr] <= clr_en_i ? '0 : push_data_i;
      end
   end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-shares one MAC by streaming NTAPS (sample, coefficient) pairs per input sample.
// Optional decimation is enabled by defining FIR_TAP_SEQUENCER_DECIM_EN.
module fir_tap_sequencer
   import fir_tap_sequencer_pkg::*;
#(
   parameter  int ADW   = 24,
   parameter  int BDW   = 18,
   parameter  int NTAPS = 16,
   parameter  int DECIM = 1,
   localparam int AW    = ptr_w(NTAPS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic signed [ADW-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  coef_wr_en,
   input  logic [AW-1:0]         coef_wr_addr,
   input  logic signed [BDW-1:0] coef_wr_data,
   output logic signed [ADW-1:0] m_axis_atdata,
   output logic signed [BDW-1:0] m_axis_btdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy
);

   if (NTAPS < 2 || DECIM < 1) begin : g_param_check
      $error("fir_tap_sequencer: NTAPS must be >= 2 and DECIM >= 1");
   end

   state_e                state_q, state_d;
   logic [AW-1:0]         tap_q, tap_d;
   logic signed [ADW-1:0] a_q, a_d;
   logic signed [BDW-1:0] b_q, b_d;
   logic                  vld_q, vld_d;
   logic                  last_q, last_d;
   logic signed [BDW-1:0] coef_mem [NTAPS];
   logic [ADW-1:0]        ring_rd;
   logic                  clr_en, push_en, adv;
   logic                  frame_start;

`ifdef FIR_TAP_SEQUENCER_DECIM_EN
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   logic [PW-1:0] phase_q, phase_d;

   assign frame_start = (phase_q == PW'(DECIM-1));

   always_comb begin
      phase_d = phase_q;
      if (push_en) begin
         phase_d = frame_start ? '0 : phase_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) phase_q <= '0;
      else     phase_q <= phase_d;
   end
`else
   assign frame_start = 1'b1;
`endif

   fir_tap_ring #(.ADW(ADW), .NTAPS(NTAPS)) u_ring (
      .clk        (clk),
      .rst        (rst),
      .clr_en_i   (clr_en),
      .clr_idx_i  (tap_q),
      .push_en_i  (push_en),
      .push_data_i(s_axis_tdata),
      .adv_i      (adv),
      .tap_i      (tap_q),
      .rd_data_o  (ring_rd)
   );

   // Reads below see the pre-edge contents, so a same-cycle write is not visible to the tap loading now.
   always_ff @(posedge clk) begin
      if (coef_wr_en && (32'(coef_wr_addr) < 32'(NTAPS))) begin
         coef_mem[coef_wr_addr] <= coef_wr_data;
      end
   end

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      a_d     = a_q;
      b_d     = b_q;
      vld_d   = vld_q;
      last_d  = last_q;
      clr_en  = 1'b0;
      push_en = 1'b0;
      adv     = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_en = 1'b1;
            if (tap_q == AW'(NTAPS-1)) begin
               tap_d   = '0;
               state_d = IDLE;
            end else begin
               tap_d = tap_q + AW'(1);
            end
         end
         IDLE: begin
            if (s_axis_tvalid) begin
               push_en = 1'b1;
               state_d = RUN;
               if (frame_start) begin
                  a_d    = s_axis_tdata;
                  b_d    = coef_mem[0];
                  vld_d  = 1'b1;
                  last_d = 1'b0;
                  tap_d  = AW'(1);
               end
            end
         end
         RUN: begin
            // A RUN cycle without a pending beat is a decimation skip: just retire the sample.
            if (!vld_q) begin
               adv     = 1'b1;
               state_d = IDLE;
            end else if (m_axis_tready) begin
               if (last_q) begin
                  vld_d   = 1'b0;
                  last_d  = 1'b0;
                  tap_d   = '0;
                  adv     = 1'b1;
                  state_d = IDLE;
               end else begin
                  a_d    = ring_rd;
                  b_d    = coef_mem[tap_q];
                  last_d = (tap_q == AW'(NTAPS-1));
                  tap_d  = tap_q + AW'(1);
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         tap_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         a_q     <= a_d;
         b_q     <= b_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
      end
   end

   assign s_axis_tready = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign m_axis_atdata = a_q;
   assign m_axis_btdata = b_q;
   assign m_axis_tvalid = vld_q;
   assign m_axis_tlast  = last_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer (NTAPS=4): vector table, directed corner cases, random stream vs. model.
module tb_fir_tap_sequencer;

   localparam int ADW   = 24;
   localparam int BDW   = 18;
   localparam int NTAPS = 4;
   localparam int AW    = 2;
`ifdef FIR_TAP_SEQUENCER_DECIM_EN
   localparam int TB_DECIM = 2;
`else
   localparam int TB_DECIM = 1;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [ADW-1:0] s_axis_tdata = '0;
   logic           s_axis_tvalid = 1'b0;
   logic           s_axis_tready;
   logic           coef_wr_en = 1'b0;
   logic [AW-1:0]  coef_wr_addr = '0;
   logic [BDW-1:0] coef_wr_data = '0;
   logic [ADW-1:0] m_axis_atdata;
   logic [BDW-1:0] m_axis_btdata;
   logic           m_axis_tvalid;
   logic           m_axis_tready = 1'b0;
   logic           m_axis_tlast;
   logic           busy;

   fir_tap_sequencer #(.ADW(ADW), .BDW(BDW), .NTAPS(NTAPS), .DECIM(TB_DECIM)) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .coef_wr_en   (coef_wr_en),
      .coef_wr_addr (coef_wr_addr),
      .coef_wr_data (coef_wr_data),
      .m_axis_atdata(m_axis_atdata),
      .m_axis_btdata(m_axis_btdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [ADW-1:0] a;
      logic [BDW-1:0] b;
      logic           last;
   } beat_t;

   typedef struct {
      logic           cw_en;
      logic [AW-1:0]  cw_addr;
      logic [BDW-1:0] cw_data;
      logic           sv;
      logic [ADW-1:0] sd;
      logic           e_sready;
      logic           e_busy;
      logic           e_vld;
      logic [ADW-1:0] e_a;
      logic [BDW-1:0] e_b;
      logic           e_last;
   } vec_t;

   int             checks = 0;
   int             errors = 0;
   int             cyc = 0;
   int             mr_mode = 0;
   int             frames = 0;
   int             phase = 0;
   beat_t          exp_q[$];
   logic [ADW-1:0] hist[$];
   logic [BDW-1:0] coef_m[NTAPS];
   logic           prev_stall = 1'b0;
   logic           prev_last_acc = 1'b0;
   beat_t          prev_beat;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic cwe, input logic [AW-1:0] cwa, input logic [BDW-1:0] cwd,
                               input logic sv, input logic [ADW-1:0] sd,
                               input logic er, input logic eb, input logic ev,
                               input logic [ADW-1:0] ea, input logic [BDW-1:0] ebb, input logic el);
      vec_t v;
      v.cw_en = cwe; v.cw_addr = cwa; v.cw_data = cwd; v.sv = sv; v.sd = sd;
      v.e_sready = er; v.e_busy = eb; v.e_vld = ev; v.e_a = ea; v.e_b = ebb; v.e_last = el;
      return v;
   endfunction

   // Model: output frame for sample n is x[n-k] (zero before the last clear) paired with coef[k].
   task automatic model_accept(input logic [ADW-1:0] x);
      beat_t e;
      hist.push_front(x);
      if (hist.size() > NTAPS) void'(hist.pop_back());
      if (phase == TB_DECIM - 1) begin
         phase = 0;
         for (int k = 0; k < NTAPS; k++) begin
            e.a    = (k < hist.size()) ? hist[k] : '0;
            e.b    = coef_m[k];
            e.last = (k == NTAPS - 1);
            exp_q.push_back(e);
         end
      end else begin
         phase++;
      end
   endtask

   function automatic logic next_mr();
      case (mr_mode)
         0:       return 1'b1;
         1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic run_cycle(input logic sv, input logic [ADW-1:0] sd, input logic mr);
      beat_t e;
      s_axis_tvalid = sv;
      s_axis_tdata  = sd;
      m_axis_tready = mr;
      if (prev_stall) begin
         check("hold_vld", m_axis_tvalid, 1);
         check("hold_a", m_axis_atdata, prev_beat.a);
         check("hold_b", m_axis_btdata, prev_beat.b);
         check("hold_last", m_axis_tlast, prev_beat.last);
      end
      if (prev_last_acc) check("sready_after_last", s_axis_tready, 1);
      if (sv && s_axis_tready) model_accept(sd);
      if (m_axis_tvalid && mr) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got a=0x%0h b=0x%0h with no beat expected at %0t",
                     m_axis_atdata, m_axis_btdata, $time);
         end else begin
            e = exp_q.pop_front();
            check("beat_a", m_axis_atdata, e.a);
            check("beat_b", m_axis_btdata, e.b);
            check("beat_last", m_axis_tlast, e.last);
         end
         if (m_axis_tlast) frames++;
      end
      prev_stall     = m_axis_tvalid && !mr;
      prev_last_acc  = m_axis_tvalid && mr && m_axis_tlast;
      prev_beat.a    = m_axis_atdata;
      prev_beat.b    = m_axis_btdata;
      prev_beat.last = m_axis_tlast;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic push_sample(input logic [ADW-1:0] x);
      int n = 0;
      while (!s_axis_tready && n < 40) begin
         run_cycle(1'b0, '0, next_mr());
         n++;
      end
      if (!s_axis_tready) check("sready_timeout", s_axis_tready, 1);
      run_cycle(1'b1, x, next_mr());
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !s_axis_tready) && n < 100) begin
         run_cycle(1'b0, '0, next_mr());
         n++;
      end
      check("drain_done", {62'b0, exp_q.size() == 0, s_axis_tready}, 64'd3);
   endtask

   task automatic reset_model();
      exp_q.delete();
      hist.delete();
      phase         = 0;
      prev_stall    = 1'b0;
      prev_last_acc = 1'b0;
   endtask

   initial begin
      vec_t          vecs[10];
      beat_t         tmp;
      logic [BDW-1:0] cw;

      vecs[0] = mk(1'b1, 2'd0, 18'd1, 1'b0, 24'd0, 1'b0, 1'b1, 1'b0, 24'd0, 18'd0, 1'b0);
      vecs[1] = mk(1'b1, 2'd1, 18'd2, 1'b0, 24'd0, 1'b0, 1'b1, 1'b0, 24'd0, 18'd0, 1'b0);
      vecs[2] = mk(1'b1, 2'd2, 18'd3, 1'b0, 24'd0, 1'b0, 1'b1, 1'b0, 24'd0, 18'd0, 1'b0);
      vecs[3] = mk(1'b1, 2'd3, 18'd4, 1'b0, 24'd0, 1'b0, 1'b1, 1'b0, 24'd0, 18'd0, 1'b0);
      vecs[4] = mk(1'b0, 2'd0, 18'd0, 1'b1, 24'd1, 1'b1, 1'b0, 1'b0, 24'd0, 18'd0, 1'b0);
      vecs[5] = mk(1'b0, 2'd0, 18'd0, 1'b0, 24'd0, 1'b0, 1'b1, 1'b1, 24'd1, 18'd1, 1'b0);
      vecs[6] = mk(1'b0, 2'd0, 18'd0, 1'b0, 24'd0, 1'b0, 1'b1, 1'b1, 24'd0, 18'd2, 1'b0);
      vecs[7] = mk(1'b0, 2'd0, 18'd0, 1'b0, 24'd0, 1'b0, 1'b1, 1'b1, 24'd0, 18'd3, 1'b0);
      vecs[8] = mk(1'b0, 2'd0, 18'd0, 1'b0, 24'd0, 1'b0, 1'b1, 1'b1, 24'd0, 18'd4, 1'b1);
      vecs[9] = mk(1'b0, 2'd0, 18'd0, 1'b0, 24'd0, 1'b1, 1'b0, 1'b0, 24'd0, 18'd0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_atdata", m_axis_atdata, 0);
      check("rst_btdata", m_axis_btdata, 0);
      check("rst_sready", s_axis_tready, 0);
      check("rst_busy", busy, 1);
      rst = 1'b0;

`ifndef FIR_TAP_SEQUENCER_DECIM_EN
      // Clear window with coefficient loads, then the first impulse frame, cycle by cycle.
      for (int i = 0; i < 10; i++) begin
         coef_wr_en    = vecs[i].cw_en;
         coef_wr_addr  = vecs[i].cw_addr;
         coef_wr_data  = vecs[i].cw_data;
         s_axis_tvalid = vecs[i].sv;
         s_axis_tdata  = vecs[i].sd;
         m_axis_tready = 1'b1;
         check($sformatf("v%0d_sready", i), s_axis_tready, vecs[i].e_sready);
         check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
         check($sformatf("v%0d_tvalid", i), m_axis_tvalid, vecs[i].e_vld);
         if (vecs[i].e_vld) begin
            check($sformatf("v%0d_a", i), m_axis_atdata, vecs[i].e_a);
            check($sformatf("v%0d_b", i), m_axis_btdata, vecs[i].e_b);
            check($sformatf("v%0d_last", i), m_axis_tlast, vecs[i].e_last);
         end
         @(posedge clk);
         #1;
      end
      coef_wr_en    = 1'b0;
      s_axis_tvalid = 1'b0;
      for (int k = 0; k < NTAPS; k++) coef_m[k] = BDW'(k + 1);
      reset_model();
      hist.push_front(24'd1);

      // Impulse moves through taps 1..3.
      mr_mode = 0;
      for (int i = 0; i < 3; i++) begin
         push_sample(24'd0);
         drain();
      end

      // Backpressure pattern 1,0,0,1.
      mr_mode = 1;
      for (int i = 0; i < 3; i++) begin
         push_sample(ADW'($urandom));
         drain();
      end

      // Coefficient writes while running: coef[1] in the cycle tap 1 loads, coef[3] while tap 1 is accepted.
      mr_mode = 0;
      push_sample(24'h000005);
      tmp      = exp_q[3];
      tmp.b    = 18'd9;
      exp_q[3] = tmp;
      coef_wr_en   = 1'b1;
      coef_wr_addr = 2'd1;
      coef_wr_data = 18'd7;
      run_cycle(1'b0, '0, 1'b1);
      coef_wr_addr = 2'd3;
      coef_wr_data = 18'd9;
      run_cycle(1'b0, '0, 1'b1);
      coef_wr_en = 1'b0;
      coef_m[1]  = 18'd7;
      coef_m[3]  = 18'd9;
      drain();
      push_sample(24'h000006);
      drain();

      // Reset while the final beat is pending.
      push_sample(24'h00000b);
      for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b1);
      check("pre_rst_last", m_axis_tlast, 1);
      rst           = 1'b1;
      m_axis_tready = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_tvalid", m_axis_tvalid, 0);
      check("midrst_tlast", m_axis_tlast, 0);
      check("midrst_busy", busy, 1);
      rst = 1'b0;
      reset_model();
      push_sample(24'h00000d);
      drain();
`else
      // Load coefficients during the clear window, then the decimation sequence 5,6,7,8.
      for (int k = 0; k < NTAPS; k++) begin
         coef_wr_en   = 1'b1;
         coef_wr_addr = AW'(k);
         coef_wr_data = BDW'(k + 1);
         coef_m[k]    = BDW'(k + 1);
         @(posedge clk);
         #1;
      end
      coef_wr_en = 1'b0;
      reset_model();
      mr_mode = 0;
      frames  = 0;
      for (int i = 5; i <= 8; i++) begin
         push_sample(ADW'(i));
         drain();
      end
      check("decim_frames", 64'(frames), 64'd2);
`endif

      // New random coefficients while idle, then a random stream with random backpressure.
      mr_mode = 0;
      for (int k = 0; k < NTAPS; k++) begin
         cw           = BDW'($urandom);
         coef_wr_en   = 1'b1;
         coef_wr_addr = AW'(k);
         coef_wr_data = cw;
         run_cycle(1'b0, '0, 1'b1);
         coef_m[k] = cw;
      end
      coef_wr_en = 1'b0;
      mr_mode = 2;
      for (int i = 0; i < 25; i++) begin
         repeat ($urandom_range(0, 2)) run_cycle(1'b0, '0, next_mr());
         push_sample(ADW'($urandom));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
